// File: rtl/seven_seg_pkg.sv
// Shared constants, payload type and BCD decode for the seven-segment scanner.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low ABCDEFG patterns for BCD 0..9 (MSB is segment A)
   localparam logic [6:0] DIGIT_PAT [10] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
      7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
   };

   typedef enum logic {
      PH_BLANK,
      PH_DRIVE
   } phase_e;

   // Display word: four BCD nibbles (leftmost in [15:12]) and per-digit dp, bit 0 leftmost
   typedef struct packed {
      logic [15:0] digits;
      logic [0:3]  dp;
   } disp_word_t;

   // Non-BCD codes render as blank
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] s;
      s = SEG_BLANK;
      if (bcd < 4'd10) s = DIGIT_PAT[bcd];
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD nibble to active-low segment pattern.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [0:6] seg_c
);

   // Table lookup with blank for codes 10..15
   always_comb begin
      seg_c = bcd_to_seg(bcd);
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode display driver with double-buffered load port.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned FRAME_HZ     = 1000,
   parameter int unsigned BLANK_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] digits_in,
   input  logic [0:3]  dp_in,
   input  logic        lz_en,
   output logic        frame_tick,
   output logic [0:3]  an,
   output logic [0:6]  seg,
   output logic        dp
);

   localparam int unsigned SLOT_CYCLES = CLK_HZ / (4 * FRAME_HZ);
   localparam int unsigned CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   if (BLANK_CYCLES == 0 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
      $error("seven_seg_scan: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < SLOT_CYCLES");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   disp_word_t       active_q, active_d;
   disp_word_t       pending_q, pending_d;
   logic             pend_full_q, pend_full_d;
   logic             frame_tick_q, frame_tick_d;
   logic [0:3]       an_q, an_d;
   logic [0:6]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             frame_end_c;
   logic [3:0]       nib_c;
   logic [0:6]       dec_seg_c;
   logic             lead_zero_c;
   phase_e           phase_c;

   // Slot/digit sequencing and pending-to-active buffer handoff
   always_comb begin
      cnt_d       = cnt_q + CNT_W'(1);
      idx_d       = idx_q;
      active_d    = active_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;
      frame_end_c = 1'b0;
      if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
         cnt_d       = '0;
         idx_d       = idx_q + 2'd1;
         frame_end_c = (idx_q == 2'd3);
      end
      if (frame_end_c && pend_full_q) begin
         active_d    = pending_q;
         pend_full_d = 1'b0;
      end else if (load_valid && !pend_full_q) begin
         pending_d   = '{digits: digits_in, dp: dp_in};
         pend_full_d = 1'b1;
      end
   end

   // Select the nibble shown in the upcoming cycle and its leading-zero status
   always_comb begin
      nib_c       = active_d.digits[3:0];
      lead_zero_c = 1'b0;
      case (idx_d)
         2'd0: begin
            nib_c       = active_d.digits[15:12];
            lead_zero_c = (active_d.digits[15:12] == 4'd0);
         end
         2'd1: begin
            nib_c       = active_d.digits[11:8];
            lead_zero_c = (active_d.digits[15:8] == 8'd0);
         end
         2'd2: begin
            nib_c       = active_d.digits[7:4];
            lead_zero_c = (active_d.digits[15:4] == 12'd0);
         end
         default: begin
            nib_c       = active_d.digits[3:0];
            lead_zero_c = 1'b0;
         end
      endcase
   end

   seven_seg_decoder u_dec (
      .bcd   (nib_c),
      .seg_c (dec_seg_c)
   );

   // Pin values for the next cycle, so pins switch on the same edge as the phase
   always_comb begin
      phase_c      = (cnt_d < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
      an_d         = AN_OFF;
      seg_d        = SEG_BLANK;
      dp_d         = 1'b1;
      frame_tick_d = frame_end_c;
      if (phase_c == PH_DRIVE) begin
         an_d  = AN_OFF ^ (4'b1000 >> idx_d);
         seg_d = (lz_en && lead_zero_c) ? SEG_BLANK : dec_seg_c;
         dp_d  = ~active_d.dp[idx_d];
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         active_q     <= '0;
         pending_q    <= '0;
         pend_full_q  <= 1'b0;
         frame_tick_q <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_full_q  <= pend_full_d;
         frame_tick_q <= frame_tick_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign load_ready = ~pend_full_q;
   assign frame_tick = frame_tick_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a frame-position reference model.
module tb_seven_seg_scan;

   localparam int FRAME = 80;
   localparam int SLOT  = 20;
   localparam int BLANK = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] digits_in = '0;
   logic [0:3]  dp_in = '0;
   logic        lz_en = 1'b0;
   logic        frame_tick;
   logic [0:3]  an;
   logic [0:6]  seg;
   logic        dp;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   seven_seg_scan #(.CLK_HZ(800), .FRAME_HZ(10), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .frame_tick (frame_tick),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   // Reference: position in frame, shown word, pending word
   int          m_p;
   logic [15:0] m_act, m_pd;
   logic [3:0]  m_adp, m_pdp;
   bit          m_full, m_tick_ok, lz_s;

   logic [6:0] seg_tbl [16];
   initial begin
      seg_tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                  7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p <= 0; m_act <= '0; m_adp <= '0; m_pd <= '0; m_pdp <= '0;
         m_full <= 1'b0; m_tick_ok <= 1'b0; lz_s <= 1'b0;
      end else begin
         m_p  <= (m_p + 1) % FRAME;
         lz_s <= lz_en;
         if (m_p == FRAME - 1) m_tick_ok <= 1'b1;
         if (m_p == FRAME - 1 && m_full) begin
            m_act <= m_pd; m_adp <= m_pdp; m_full <= 1'b0;
         end else if (load_valid && !m_full) begin
            m_pd <= digits_in; m_pdp <= dp_in; m_full <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h (frame pos %0d)", name, $time, act, exp, m_p);
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      int slot, c;
      logic [15:0] upper;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      if (rst_n && chk_en) begin
         slot  = m_p / SLOT;
         c     = m_p % SLOT;
         e_an  = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         if (c >= BLANK) begin
            upper = m_act >> (4 * (3 - slot));
            e_an  = 4'hF ^ (4'h8 >> slot);
            e_seg = seg_tbl[upper[3:0]];
            if (lz_s && slot < 3 && upper == 16'd0) e_seg = 7'h7F;
            e_dp  = ~m_adp[3 - slot];
         end
         chk("an", 32'(an), 32'(e_an));
         chk("seg", 32'(seg), 32'(e_seg));
         chk("dp", 32'(dp), 32'(e_dp));
         chk("frame_tick", 32'(frame_tick), 32'(m_p == 0 && m_tick_ok));
         chk("load_ready", 32'(load_ready), 32'(!m_full));
      end
   end

   task automatic wait_pos(input int tgt);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_p != tgt && n < 200);
      if (m_p != tgt) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_pos: position %0d not reached, at %0d", tgt, m_p);
      end
      #1;
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] p);
      digits_in  = d;
      dp_in      = p;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      #1;
   endtask

   initial begin
      logic [15:0] r;
      // Reset state
      #12;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_ready", 32'(load_ready), 32'h1);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      @(negedge clk); #2 rst_n = 1'b1; chk_en = 1'b1;

      // First frame after reset: anode sequence and tick period
      wait_pos(3);  chk("f0_blank_an", 32'(an), 32'hF);
      wait_pos(4);  chk("f0_an0", 32'(an), 32'h7); chk("f0_seg0", 32'(seg), 32'h01);
      wait_pos(24); chk("f0_an1", 32'(an), 32'hB);
      wait_pos(44); chk("f0_an2", 32'(an), 32'hD);
      wait_pos(79); chk("f0_an3", 32'(an), 32'hE);
      wait_pos(0);  chk("tick_80", 32'(frame_tick), 32'h1); chk("tick_an", 32'(an), 32'hF);
      wait_pos(1);  chk("tick_once", 32'(frame_tick), 32'h0);

      // Mid-frame load is held until the next frame
      wait_pos(30); load(16'h1234, 4'b0100);
      chk("pend_ready", 32'(load_ready), 32'h0);
      wait_pos(64); chk("same_frame", 32'(seg), 32'h01);
      wait_pos(4);  chk("l1_d0", 32'(seg), 32'h4F);
      wait_pos(24); chk("l1_d1", 32'(seg), 32'h12); chk("l1_dp1", 32'(dp), 32'h0);
      wait_pos(44); chk("l1_d2", 32'(seg), 32'h06); chk("l1_dp2", 32'(dp), 32'h1);
      wait_pos(64); chk("l1_d3", 32'(seg), 32'h4C);

      // Leading-zero suppression on and off
      lz_en = 1'b1; load(16'h0070, 4'b0000);
      wait_pos(4);  chk("lz_d0", 32'(seg), 32'h7F); chk("lz_an0", 32'(an), 32'h7);
      wait_pos(24); chk("lz_d1", 32'(seg), 32'h7F);
      wait_pos(44); chk("lz_d2", 32'(seg), 32'h0F);
      wait_pos(64); chk("lz_d3", 32'(seg), 32'h01);
      lz_en = 1'b0;
      wait_pos(4);  chk("nolz_d0", 32'(seg), 32'h01);
      wait_pos(24); chk("nolz_d1", 32'(seg), 32'h01);

      // Second offer while pending is full is ignored
      wait_pos(64); load(16'h5678, 4'b0001);
      digits_in = 16'h9999; dp_in = 4'b1111; load_valid = 1'b1;
      wait_pos(70); chk("full_ready", 32'(load_ready), 32'h0);
      load_valid = 1'b0;
      wait_pos(79); chk("full_ready_end", 32'(load_ready), 32'h0);
      wait_pos(0);  chk("swap_ready", 32'(load_ready), 32'h1);
      wait_pos(4);  chk("first_word", 32'(seg), 32'h24);
      wait_pos(64); chk("first_d3", 32'(seg), 32'h00); chk("first_dp3", 32'(dp), 32'h0);

      // Load on the frame-end cycle goes to pending only
      wait_pos(79); load(16'h4321, 4'b0000);
      chk("coinc_ready", 32'(load_ready), 32'h0);
      wait_pos(4);  chk("coinc_old", 32'(seg), 32'h24);
      wait_pos(0);  chk("coinc_swap_ready", 32'(load_ready), 32'h1);
      wait_pos(4);  chk("coinc_new", 32'(seg), 32'h4C);

      // Non-BCD nibble blanks segments but still drives the anode
      load(16'h0C00, 4'b0000);
      wait_pos(24); wait_pos(24);
      chk("nbcd_an", 32'(an), 32'hB); chk("nbcd_seg", 32'(seg), 32'h7F);

      // Asynchronous reset mid-DRIVE discards the pending word
      load(16'h1111, 4'b1111);
      wait_pos(30); @(posedge clk); #2 rst_n = 1'b0; #1;
      chk("arst_an", 32'(an), 32'hF);
      chk("arst_seg", 32'(seg), 32'h7F);
      chk("arst_dp", 32'(dp), 32'h1);
      chk("arst_ready", 32'(load_ready), 32'h1);
      @(negedge clk); #2 rst_n = 1'b1;

      // Randomized loads and suppression toggles
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            r = 16'($urandom);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) r[4*k +: 4] = 4'd0;
            digits_in  = r;
            dp_in      = 4'($urandom);
            load_valid = 1'b1;
         end else begin
            load_valid = 1'b0;
         end
         if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      end
      load_valid = 1'b0;
      repeat (FRAME) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
